bk_adder: RTL and testbench
===========================

BK_ADDER -- requirements
Module: bk_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; SHALL be a power of two ≥ 4.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 Port: a  input  WIDTH  unsigned addend.
REQ-005 Port: b  input  WIDTH  unsigned addend.
REQ-006 Port: s  output  WIDTH+1  registered unsigned sum; s[WIDTH] is the carry-out.
REQ-007 Block SHALL have one clock and a synchronous active-high reset; there SHALL be no other clock, enable, carry-in or handshake port.

Function
REQ-008 Sum: s SHALL equal the zero-extended a + b, computed WIDTH+1 bits wide, with no overflow or wrap.
REQ-009 Bit terms: per bit i, g[i] = a[i] & b[i] and p[i] = a[i] ^ b[i]. Implicit carry-in SHALL be 0.
REQ-010 Carry network SHALL be a Brent-Kung parallel prefix built from a single (G,P) operator: (Gh,Ph)o(Gl,Pl) = (Gh | Ph&Gl, Ph&Pl).
REQ-011 Up-sweep: log2(WIDTH) levels. At level k (k=1..log2 WIDTH), combine span 2^(k-1) into span 2^k at bit indices i where (i+1) mod 2^k = 0.
REQ-012 Down-sweep: log2(WIDTH)-1 levels. These fill the remaining prefixes at indices i = 3·2^(k-1)-1 + m·2^k, from the largest k down to k=1.
REQ-013 Node count: for WIDTH=16, the network SHALL use exactly 26 prefix operators. Depth SHALL be 2·log2(WIDTH)-1 operator levels (7 for WIDTH=16).
REQ-014 Sum bits: c[0]=0 and c[i] = G[i-1:0] for i ≥ 1. Then s[i] = p[i] ^ c[i] for i < WIDTH, and s[WIDTH] = G[WIDTH-1:0].
REQ-015 Timing: a and b are sampled at a rising edge, and the corresponding sum SHALL appear on s immediately after that same edge (latency 1 clock). The prefix network between inputs and the s register SHALL be purely combinational.
REQ-016 Back-to-back: a new operand pair SHALL be accepted every cycle with no stall. s changes only on clock edges.
REQ-017 Boundaries: all-ones + all-ones SHALL give 2^(WIDTH+1)-2 with s[WIDTH]=1. all-ones + 1 SHALL give exactly 2^WIDTH (full carry ripple through every prefix). 0+0 SHALL give 0.
REQ-018 X-free: with known a and b, s SHALL never be X after reset is released.

Reset
REQ-019 While rst=1 at a rising edge, s SHALL become 0 regardless of a and b.
REQ-020 On the first rising edge with rst=0, s SHALL load a+b from the inputs present at that edge. No operand sampled during reset is retained.
REQ-021 Reset asserted mid-stream SHALL clear s at that edge. The operation in flight is discarded, not completed.

Structure
REQ-022 Shared package bk_adder_pkg SHALL hold:
- default WIDTH constant (16);
- derived LEVELS = log2(WIDTH);
- a gp_t struct/typedef {g, p} used for prefix-network wiring.
REQ-023 Sub-module bk_prefix_cell SHALL implement the REQ-010 operator (inputs Gh, Ph, Gl, Pl; outputs G, P). bk_adder instantiates it for every node, generated by level loops.
REQ-024 Only the s register SHALL be sequential. No latches.

Verification
REQ-025 rst=1 for 2 cycles with a=16'hFFFF, b=16'hFFFF -> s=0 at each edge; rst released -> next edge s=131070.
REQ-026 a=65535, b=123 -> one edge later s=65658 (s[16]=1).
REQ-027 a=65535, b=1 -> s=65536; then a=0, b=0 on the next edge -> s=0 (full ripple in both directions).
REQ-028 Sweep: a=0..65499 step 14, b=0..255 step 14, one new pair per cycle. Each result is checked one cycle after sampling against a+b computed 17 bits wide; required error count is 0.
REQ-029 Mid-stream reset: pairs streaming, rst=1 for one edge -> s=0 that cycle; next edge s = sum of the inputs present at that edge.
REQ-030 Single-bit checks: a=2^i, b=2^i for i=0..15 -> s=2^(i+1); a=16'h5555, b=16'hAAAA -> s=65535.

Source files
------------

// File: rtl/bk_adder_pkg.sv
// Shared constants and prefix-network wiring types for the Brent-Kung adder.
package bk_adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned LEVELS        = $clog2(WIDTH_DEFAULT);

  // Generate/propagate pair carried through every prefix node.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung prefix operator: merges a high span (gh,ph) with the adjacent low span (gl,pl).
module bk_prefix_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/bk_adder.sv
// Registered WIDTH-bit unsigned adder with a Brent-Kung carry network; s[WIDTH] is carry-out.
module bk_adder
  import bk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   s
);

  localparam int unsigned LV     = $clog2(WIDTH);
  localparam int unsigned STAGES = 2 * LV;

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] prefix_g;
  logic [WIDTH-1:0] unused_prefix_p;
  logic [WIDTH-1:0] carry;
  logic [WIDTH:0]   sum_c;

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  // Stage 0 holds bit terms; stages 1..LV sweep up, LV+1..2*LV-1 sweep down.
  for (genvar j = 0; j < STAGES; j++) begin : stage
    gp_t node [WIDTH];
    if (j == 0) begin : g_bits
      for (genvar i = 0; i < WIDTH; i++) begin : g_col
        assign node[i] = '{g: g_bit[i], p: p_bit[i]};
      end
    end else begin : g_net
      localparam int K = (j <= LV) ? j : (2 * LV - j);
      localparam int H = 1 << (K - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_col
        localparam bit IS_NODE = (j <= LV)
                               ? (((i + 1) % (2 * H)) == 0)
                               : (((i + 1) >= (3 * H)) && (((i + 1 - 3 * H) % (2 * H)) == 0));
        if (IS_NODE) begin : g_op
          bk_prefix_cell u_cell (
            .gh (stage[j-1].node[i].g),
            .ph (stage[j-1].node[i].p),
            .gl (stage[j-1].node[i-H].g),
            .pl (stage[j-1].node[i-H].p),
            .g  (node[i].g),
            .p  (node[i].p)
          );
        end else begin : g_pass
          assign node[i] = stage[j-1].node[i];
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    assign prefix_g[i]        = stage[STAGES-1].node[i].g;
    assign unused_prefix_p[i] = stage[STAGES-1].node[i].p;
  end

  // Carry into bit i is the group generate of bits i-1..0; carry-in is zero.
  assign carry = {prefix_g[WIDTH-2:0], 1'b0};
  assign sum_c = {prefix_g[WIDTH-1], p_bit ^ carry};

  always_ff @(posedge clk) begin
    if (rst) s <= '0;
    else     s <= sum_c;
  end

endmodule

// File: tb/tb_bk_adder.sv
// Self-checking bench for bk_adder: directed boundaries, sweep and random streams vs integer sums.
module tb_bk_adder;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W:0]   s;

  int checks;
  int errors;

  bk_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .s   (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sum(input int unsigned x, input int unsigned y);
    int unsigned t;
    t = x + y;
    return (W+1)'(t);
  endfunction

  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      apply(16'hFFFF, 16'hFFFF);
      checks++;
      if (s !== '0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %0d want 0", n, s);
      end
    end
    rst = 1'b0;
    apply(16'hFFFF, 16'hFFFF);
    checks++;
    if (s !== 17'd131070) begin
      errors++;
      $display("FAIL reset_release: got %0d want 131070", s);
    end
  endtask

  task automatic test_boundaries();
    apply(16'd65535, 16'd123);
    checks++;
    if (s !== 17'd65658) begin
      errors++;
      $display("FAIL max_plus_123: got %0d want 65658", s);
    end
    apply(16'hFFFF, 16'd1);
    checks++;
    if (s !== 17'd65536) begin
      errors++;
      $display("FAIL full_ripple_up: got %0d want 65536", s);
    end
    apply(16'd0, 16'd0);
    checks++;
    if (s !== 17'd0) begin
      errors++;
      $display("FAIL full_ripple_down: got %0d want 0", s);
    end
    apply(16'h5555, 16'hAAAA);
    checks++;
    if (s !== 17'd65535) begin
      errors++;
      $display("FAIL alternating: got %0d want 65535", s);
    end
  endtask

  task automatic test_single_bit();
    int unsigned v;
    for (int i = 0; i < W; i++) begin
      v = 32'd1 << i;
      apply(W'(v), W'(v));
      checks++;
      if (s !== (W+1)'(v * 2)) begin
        errors++;
        $display("FAIL single_bit %0d: got %0d want %0d", i, s, v * 2);
      end
    end
  endtask

  task automatic test_sweep();
    int unsigned x;
    int unsigned y;
    int          idx;
    int          bad;
    idx = 0;
    bad = 0;
    for (x = 0; x <= 65499; x += 14) begin
      y = 14 * (idx % 19);
      apply(W'(x), W'(y));
      checks++;
      if (s !== ref_sum(x, y)) begin
        errors++;
        bad++;
        if (bad <= 8) $display("FAIL sweep %0d+%0d: got %0d want %0d", x, y, s, ref_sum(x, y));
      end
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    int unsigned x;
    int unsigned y;
    for (int n = 0; n < 500; n++) begin
      x = $urandom_range(65535);
      y = $urandom_range(65535);
      apply(W'(x), W'(y));
      checks++;
      if (s !== ref_sum(x, y)) begin
        errors++;
        $display("FAIL random %0d+%0d: got %0d want %0d", x, y, s, ref_sum(x, y));
      end
    end
  endtask

  task automatic test_midstream_reset();
    int unsigned x;
    int unsigned y;
    for (int n = 0; n < 5; n++) begin
      x = $urandom_range(65535);
      y = $urandom_range(65535);
      apply(W'(x), W'(y));
      checks++;
      if (s !== ref_sum(x, y)) begin
        errors++;
        $display("FAIL stream %0d+%0d: got %0d want %0d", x, y, s, ref_sum(x, y));
      end
    end
    rst = 1'b1;
    apply(16'hFFFF, 16'h8001);
    checks++;
    if (s !== '0) begin
      errors++;
      $display("FAIL midstream_reset: got %0d want 0", s);
    end
    rst = 1'b0;
    x = $urandom_range(65535);
    y = $urandom_range(65535);
    apply(W'(x), W'(y));
    checks++;
    if (s !== ref_sum(x, y)) begin
      errors++;
      $display("FAIL after_midstream_reset %0d+%0d: got %0d want %0d", x, y, s, ref_sum(x, y));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    a      = '0;
    b      = '0;
    test_reset();
    test_boundaries();
    test_single_bit();
    test_sweep();
    test_back_to_back();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
